// File: rtl/ysyx_24070003_ifu_fq.sv
// Instruction fetch unit with a credit-bounded multi-outstanding I-cache port
// and a small FIFO decoupling fetch from decode; stale responses are squashed by count.
module ysyx_24070003_ifu_fq #(
  parameter logic [31:0] RESET_PC  = 32'h3000_0000,
  parameter int          FQ_DEPTH  = 4,
  parameter int          MAX_OUTST = 2,
  parameter int          CNT_W     = 64
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             exu_ifu_flush,
  input  logic [31:0]      exu_ifu_pc,
  input  logic             fence_i,
  input  logic             stall,
  output logic             ifu_icache_arvalid,
  output logic [31:0]      ifu_icache_araddr,
  input  logic             icache_ifu_arready,
  input  logic             icache_ifu_rvalid,
  input  logic [31:0]      icache_ifu_rdata,
  input  logic [31:0]      icache_ifu_raddr,
  input  logic [1:0]       icache_ifu_resp,
  output logic             ifu_idu_valid,
  output logic [31:0]      ifu_idu_instr,
  output logic [31:0]      ifu_idu_pc,
  output logic             ifu_idu_fault,
  input  logic             idu_ifu_ready,
  output logic             fence_idle,
  output logic [CNT_W-1:0] ifu_count
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int OCC_W = $clog2(FQ_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int SUM_W = $clog2(FQ_DEPTH + MAX_OUTST + 1);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FQ_DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTST);
  localparam logic [SUM_W-1:0] SUM_LIM  = SUM_W'(FQ_DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fq_entry_t;

  logic [31:0]      pc_q, pc_d;
  fq_entry_t        fq_q [FQ_DEPTH];
  fq_entry_t        fq_d [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [OUT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             issue;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] credit_sum;
  fq_entry_t        head;

  // Issue only while queued plus in-flight entries leave room, so every response has a slot.
  always_comb begin
    credit_sum         = SUM_W'(occ_q) + SUM_W'(outst_q);
    ifu_icache_arvalid = rstn && !stall && !exu_ifu_flush && !fence_i &&
                         (outst_q < OUT_MAX) && (credit_sum < SUM_LIM);
    ifu_icache_araddr  = pc_q;
    issue              = ifu_icache_arvalid && icache_ifu_arready;
    push               = icache_ifu_rvalid && (drop_q == '0) && !exu_ifu_flush;
    pop                = (occ_q != '0) && idu_ifu_ready && !exu_ifu_flush;
  end

  always_comb begin
    pc_d     = pc_q;
    fq_d     = fq_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    drop_d   = drop_q;
    count_d  = count_q;
    outst_d  = outst_q + OUT_W'(issue) - OUT_W'(icache_ifu_rvalid);

    if (exu_ifu_flush) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d     = exu_ifu_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      drop_d   = outst_q - OUT_W'(icache_ifu_rvalid);
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
      end
      if (icache_ifu_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - OUT_W'(1);
      end
      if (push) begin
        fq_d[wr_ptr_q] = '{instr: icache_ifu_rdata,
                           pc:    icache_ifu_raddr,
                           fault: (icache_ifu_resp != 2'b00)};
        wr_ptr_d       = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      fq_q     <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      fq_q     <= fq_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    head          = fq_q[rd_ptr_q];
    ifu_idu_valid = (occ_q != '0);
    ifu_idu_instr = head.instr;
    ifu_idu_pc    = head.pc;
    ifu_idu_fault = ifu_idu_valid && head.fault;
    fence_idle    = (outst_q == '0) && (occ_q == '0);
    ifu_count     = count_q;
  end

  a_no_push_full: assert property (@(posedge clock) disable iff (!rstn)
    !(push && (occ_q == OCC_FULL)));
  a_no_resp_idle: assert property (@(posedge clock) disable iff (!rstn)
    !(icache_ifu_rvalid && (outst_q == '0)));

endmodule

// File: tb/tb_ysyx_24070003_ifu_fq.sv
// Bench for the fetch-queue IFU: a fixed vector table, directed corner sequences,
// and a randomized run checked against a queue-based reference model.
module tb_ysyx_24070003_ifu_fq;

  localparam int          FQ_DEPTH  = 4;
  localparam int          MAX_OUTST = 2;
  localparam int          CNT_W     = 64;
  localparam logic [31:0] RESET_PC  = 32'h3000_0000;
  localparam logic [31:0] B         = 32'h3000_0000;

  logic             clock;
  logic             rstn;
  logic             exu_ifu_flush;
  logic [31:0]      exu_ifu_pc;
  logic             fence_i;
  logic             stall;
  logic             ifu_icache_arvalid;
  logic [31:0]      ifu_icache_araddr;
  logic             icache_ifu_arready;
  logic             icache_ifu_rvalid;
  logic [31:0]      icache_ifu_rdata;
  logic [31:0]      icache_ifu_raddr;
  logic [1:0]       icache_ifu_resp;
  logic             ifu_idu_valid;
  logic [31:0]      ifu_idu_instr;
  logic [31:0]      ifu_idu_pc;
  logic             ifu_idu_fault;
  logic             idu_ifu_ready;
  logic             fence_idle;
  logic [CNT_W-1:0] ifu_count;

  int checks = 0;
  int errors = 0;

  ysyx_24070003_ifu_fq #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH),
    .MAX_OUTST(MAX_OUTST),
    .CNT_W    (CNT_W)
  ) dut (
    .clock             (clock),
    .rstn              (rstn),
    .exu_ifu_flush     (exu_ifu_flush),
    .exu_ifu_pc        (exu_ifu_pc),
    .fence_i           (fence_i),
    .stall             (stall),
    .ifu_icache_arvalid(ifu_icache_arvalid),
    .ifu_icache_araddr (ifu_icache_araddr),
    .icache_ifu_arready(icache_ifu_arready),
    .icache_ifu_rvalid (icache_ifu_rvalid),
    .icache_ifu_rdata  (icache_ifu_rdata),
    .icache_ifu_raddr  (icache_ifu_raddr),
    .icache_ifu_resp   (icache_ifu_resp),
    .ifu_idu_valid     (ifu_idu_valid),
    .ifu_idu_instr     (ifu_idu_instr),
    .ifu_idu_pc        (ifu_idu_pc),
    .ifu_idu_fault     (ifu_idu_fault),
    .idu_ifu_ready     (idu_ifu_ready),
    .fence_idle        (fence_idle),
    .ifu_count         (ifu_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall, fence, flush;
    logic [31:0] fpc;
    logic        ready, arready, rvalid;
    logic [31:0] raddr;
    logic [1:0]  resp;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
    logic        e_fault, e_idle;
    logic [63:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic [1:0]  resp;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  int          m_outst, m_drop, cyc;
  logic [31:0] m_pc;
  logic [63:0] m_count;
  int          lat_min, lat_max, fault_pct;

  // The I-cache answers with a value derived from the address so the bench can predict it.
  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  function automatic vec_t vec(input logic st, fe, fl, input logic [31:0] fpc,
                               input logic rdy, arr, rv, input logic [31:0] ra,
                               input logic [1:0] rs, input logic e_arv,
                               input logic [31:0] e_addr, input logic e_val,
                               input logic [31:0] e_pc, input logic e_fault, e_idle,
                               input logic [63:0] e_cnt);
    vec_t v;
    v.stall = st; v.fence = fe; v.flush = fl; v.fpc = fpc;
    v.ready = rdy; v.arready = arr; v.rvalid = rv; v.raddr = ra; v.resp = rs;
    v.e_arv = e_arv; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    v.e_fault = e_fault; v.e_idle = e_idle; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, fe, fl, input logic [31:0] fpc,
                               input logic rdy, arr, rv, input logic [31:0] ra,
                               input logic [1:0] rs);
    @(negedge clock);
    stall              = st;
    fence_i            = fe;
    exu_ifu_flush      = fl;
    exu_ifu_pc         = fpc;
    idu_ifu_ready      = rdy;
    icache_ifu_arready = arr;
    icache_ifu_rvalid  = rv;
    icache_ifu_raddr   = ra;
    icache_ifu_rdata   = instrOf(ra);
    icache_ifu_resp    = rs;
    #1;
  endtask

  task automatic modelReset();
    mq.delete();
    pend.delete();
    m_outst = 0;
    m_drop  = 0;
    m_pc    = RESET_PC;
    m_count = 64'd0;
    cyc     = 0;
  endtask

  task automatic doReset();
    @(negedge clock);
    rstn               = 1'b0;
    stall              = 1'b0;
    fence_i            = 1'b0;
    exu_ifu_flush      = 1'b0;
    idu_ifu_ready      = 1'b0;
    icache_ifu_arready = 1'b0;
    icache_ifu_rvalid  = 1'b0;
    #1;
    checkOutput("rst_arvalid", 64'(ifu_icache_arvalid), 64'd0);
    checkOutput("rst_araddr", 64'(ifu_icache_araddr), 64'(RESET_PC));
    checkOutput("rst_valid", 64'(ifu_idu_valid), 64'd0);
    checkOutput("rst_fault", 64'(ifu_idu_fault), 64'd0);
    checkOutput("rst_idle", 64'(fence_idle), 64'd1);
    checkOutput("rst_count", ifu_count, 64'd0);
    @(negedge clock);
    rstn = 1'b1;
    modelReset();
  endtask

  // One model-checked cycle: drive, compare every output with the model, then advance it.
  task automatic runCycle(input logic st, fe, fl, input logic [31:0] fpc,
                          input logic rdy, arr, want);
    logic        rv, exp_arv, issue;
    logic [31:0] ra;
    logic [1:0]  rs;
    req_t        nr;
    ent_t        ne;
    rv = 1'b0; ra = 32'h0; rs = 2'b00;
    if (want && pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      ra = pend[0].addr;
      rs = pend[0].resp;
    end
    applyStimulus(st, fe, fl, fpc, rdy, arr, rv, ra, rs);
    exp_arv = !st && !fl && !fe && (m_outst < MAX_OUTST) &&
              (mq.size() + m_outst < FQ_DEPTH);
    checkOutput($sformatf("c%0d_arvalid", cyc), 64'(ifu_icache_arvalid), 64'(exp_arv));
    checkOutput($sformatf("c%0d_araddr", cyc), 64'(ifu_icache_araddr), 64'(m_pc));
    checkOutput($sformatf("c%0d_valid", cyc), 64'(ifu_idu_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkOutput($sformatf("c%0d_pc", cyc), 64'(ifu_idu_pc), 64'(mq[0].pc));
      checkOutput($sformatf("c%0d_instr", cyc), 64'(ifu_idu_instr), 64'(mq[0].instr));
      checkOutput($sformatf("c%0d_fault", cyc), 64'(ifu_idu_fault), 64'(mq[0].fault));
    end
    checkOutput($sformatf("c%0d_idle", cyc), 64'(fence_idle),
                64'(m_outst == 0 && mq.size() == 0));
    checkOutput($sformatf("c%0d_count", cyc), ifu_count, m_count);

    issue = exp_arv && arr;
    if (rv) void'(pend.pop_front());
    if (issue) begin
      nr.addr = m_pc;
      nr.due  = cyc + $urandom_range(lat_max, lat_min);
      nr.resp = ($urandom_range(99, 0) < fault_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
      pend.push_back(nr);
    end
    if (fl) begin
      m_outst = m_outst - int'(rv);
      m_drop  = m_outst;
      mq.delete();
      m_pc    = fpc;
    end else begin
      if (mq.size() != 0 && rdy) begin
        void'(mq.pop_front());
        m_count = m_count + 64'd1;
      end
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else begin
          ne.instr = instrOf(ra);
          ne.pc    = ra;
          ne.fault = (rs != 2'b00);
          mq.push_back(ne);
        end
      end
      m_outst = m_outst + int'(issue) - int'(rv);
      if (issue) m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(posedge clock);
  endtask

  vec_t vecs[19];

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic        fe_state;
    logic [31:0] r;
    logic [31:0] fpc;

    rstn = 1'b0; stall = 1'b0; fence_i = 1'b0; exu_ifu_flush = 1'b0;
    exu_ifu_pc = 32'h0; idu_ifu_ready = 1'b0; icache_ifu_arready = 1'b0;
    icache_ifu_rvalid = 1'b0; icache_ifu_rdata = 32'h0; icache_ifu_raddr = 32'h0;
    icache_ifu_resp = 2'b00;
    lat_min = 1; lat_max = 1; fault_pct = 0;

    // Hand-computed trace: credits, fault entry at +4, fence drain, then redirect.
    vecs[0]  = vec(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b0,B,      1'b0,32'h0, 1'b0,1'b1,64'd0);
    vecs[1]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b0,1'b0,32'h0,2'd0, 1'b1,B,      1'b0,32'h0, 1'b0,1'b1,64'd0);
    vecs[2]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b1,B,      1'b0,32'h0, 1'b0,1'b1,64'd0);
    vecs[3]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b1,B+32'h4,1'b0,32'h0, 1'b0,1'b0,64'd0);
    vecs[4]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b1,B,    2'd0, 1'b0,B+32'h8,1'b0,32'h0, 1'b0,1'b0,64'd0);
    vecs[5]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b1,B+32'h4,2'd2,1'b1,B+32'h8,1'b1,B,    1'b0,1'b0,64'd0);
    vecs[6]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b1,B+32'hC,1'b1,B,     1'b0,1'b0,64'd0);
    vecs[7]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b1,B+32'h8,2'd0,1'b0,B+32'h10,1'b1,B,   1'b0,1'b0,64'd0);
    vecs[8]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h10,1'b1,B,    1'b0,1'b0,64'd0);
    vecs[9]  = vec(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h10,1'b1,B,    1'b0,1'b0,64'd0);
    vecs[10] = vec(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b1,B+32'h10,1'b1,B+32'h4,1'b1,1'b0,64'd1);
    vecs[11] = vec(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b1,B+32'hC,2'd0,1'b0,B+32'h14,1'b1,B+32'h8,1'b0,1'b0,64'd2);
    vecs[12] = vec(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h14,1'b1,B+32'hC,1'b0,1'b0,64'd3);
    vecs[13] = vec(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b1,B+32'h10,2'd0,1'b0,B+32'h14,1'b0,32'h0,1'b0,1'b0,64'd4);
    vecs[14] = vec(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h14,1'b1,B+32'h10,1'b0,1'b0,64'd4);
    vecs[15] = vec(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h14,1'b1,B+32'h10,1'b0,1'b0,64'd4);
    vecs[16] = vec(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h14,1'b0,32'h0, 1'b0,1'b1,64'd5);
    vecs[17] = vec(1'b0,1'b0,1'b1,32'h8000_0000, 1'b1,1'b1,1'b0,32'h0,2'd0, 1'b0,B+32'h14,1'b0,32'h0,1'b0,1'b1,64'd5);
    vecs[18] = vec(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,1'b0,32'h0,2'd0, 1'b1,32'h8000_0000,1'b0,32'h0,1'b0,1'b1,64'd5);

    doReset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].fence, vecs[i].flush, vecs[i].fpc,
                    vecs[i].ready, vecs[i].arready, vecs[i].rvalid,
                    vecs[i].raddr, vecs[i].resp);
      checkOutput($sformatf("vec%0d_arvalid", i), 64'(ifu_icache_arvalid), 64'(vecs[i].e_arv));
      checkOutput($sformatf("vec%0d_araddr", i), 64'(ifu_icache_araddr), 64'(vecs[i].e_addr));
      checkOutput($sformatf("vec%0d_valid", i), 64'(ifu_idu_valid), 64'(vecs[i].e_val));
      checkOutput($sformatf("vec%0d_idle", i), 64'(fence_idle), 64'(vecs[i].e_idle));
      checkOutput($sformatf("vec%0d_count", i), ifu_count, vecs[i].e_cnt);
      if (vecs[i].e_val) begin
        checkOutput($sformatf("vec%0d_pc", i), 64'(ifu_idu_pc), 64'(vecs[i].e_pc));
        checkOutput($sformatf("vec%0d_instr", i), 64'(ifu_idu_instr), 64'(instrOf(vecs[i].e_pc)));
        checkOutput($sformatf("vec%0d_fault", i), 64'(ifu_idu_fault), 64'(vecs[i].e_fault));
      end
    end

    // Streaming with a 1-cycle I-cache: eight pops after ten cycles.
    doReset();
    for (int i = 0; i < 10; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    #2;
    checkOutput("stream_count8", ifu_count, 64'd8);

    // Flush with two in flight and two queued: both late responses are dropped.
    doReset();
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    runCycle(1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("flush_valid_drop", 64'(ifu_idu_valid), 64'd0);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    #2;
    checkOutput("flush_first_valid", 64'(ifu_idu_valid), 64'd1);
    checkOutput("flush_first_pc", 64'(ifu_idu_pc), 64'h8000_0000);
    for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // Flush coinciding with a response and a would-be pop.
    doReset();
    for (int i = 0; i < 2; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    runCycle(1'b0, 1'b0, 1'b1, 32'h9000_0000, 1'b1, 1'b1, 1'b1);
    #2;
    checkOutput("flushpop_valid", 64'(ifu_idu_valid), 64'd0);
    checkOutput("flushpop_count", ifu_count, 64'd0);
    for (int i = 0; i < 6; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    // fence.i with one in flight and two queued drains to idle.
    doReset();
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("fence_no_issue", 64'(ifu_icache_arvalid), 64'd0);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    #2;
    checkOutput("fence_not_idle", 64'(fence_idle), 64'd0);
    runCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    #2;
    checkOutput("fence_idle_rise", 64'(fence_idle), 64'd1);
    checkOutput("fence_still_blocked", 64'(ifu_icache_arvalid), 64'd0);

    // Randomized traffic with variable latency, faults, flushes and a mid-run reset.
    lat_min = 1; lat_max = 4; fault_pct = 15;
    fe_state = 1'b0;
    doReset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) doReset();
      if ($urandom_range(99, 0) < 4) fe_state = !fe_state;
      r   = $urandom;
      fpc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : (r & ~32'h3);
      runCycle($urandom_range(4, 0) == 0, fe_state, $urandom_range(99, 0) < 4, fpc,
               $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8,
               $urandom_range(9, 0) < 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
